// File: rtl/alu_sequencer.sv
// alu_sequencer: issue-side controller for the OrgaSmall alu.
// Holds an 8-entry register file and runs one instruction per four cycles.
`timescale 1ns/1ps
module alu_sequencer #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [15:0]          instr,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    output logic [3:0]           alu_op,
    input  logic [WORD_SIZE-1:0] alu_out,
    input  logic                 wr_en,
    input  logic [2:0]           wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic [2:0]           rd_addr,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic                 flag_z,
    output logic                 flag_n,
    output logic                 done,
    output logic                 illegal
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SHL = 4'd2;
    localparam logic [3:0] OP_SRA = 4'd3;
    localparam logic [3:0] OP_SRL = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_EQ  = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RETIRE
    } state_t;

    state_t               state;
    logic [WORD_SIZE-1:0] rf [8];
    logic [WORD_SIZE-1:0] result_q;
    logic [2:0]           rx_q;
    logic                 legal_q;
    logic                 cmp_q;

    logic [4:0]           opcode;
    logic [2:0]           rx;
    logic [2:0]           ry;
    logic [3:0]           dec_op;
    logic                 dec_legal;
    logic                 dec_cmp;
    logic                 accept;
    logic                 wb_en;

    assign opcode  = instr[15:11];
    assign rx      = instr[10:8];
    assign ry      = instr[7:5];
    assign accept  = (state == IDLE) && instr_valid && instr_ready;
    assign wb_en   = (state == RETIRE) && legal_q && !cmp_q;
    assign rd_data = rf[rd_addr];

    // Illegal opcodes still run through the alu as ADD; the result is dropped.
    always_comb begin
        dec_op    = OP_ADD;
        dec_legal = 1'b1;
        dec_cmp   = 1'b0;
        case (opcode)
            5'h01: dec_op = OP_ADD;
            5'h02: dec_op = OP_SUB;
            5'h03: dec_op = OP_AND;
            5'h04: dec_op = OP_OR;
            5'h05: dec_op = OP_XOR;
            5'h06: dec_op = OP_SHL;
            5'h07: dec_op = OP_SRA;
            5'h08: dec_op = OP_SRL;
            5'h09: begin
                dec_op  = OP_EQ;
                dec_cmp = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= OP_ADD;
            result_q    <= '0;
            rx_q        <= '0;
            legal_q     <= 1'b0;
            cmp_q       <= 1'b0;
            flag_z      <= 1'b0;
            flag_n      <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a       <= rf[rx];
                        alu_b       <= rf[ry];
                        alu_op      <= dec_op;
                        rx_q        <= rx;
                        legal_q     <= dec_legal;
                        cmp_q       <= dec_cmp;
                        instr_ready <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    result_q <= alu_out;
                    done     <= 1'b1;
                    illegal  <= !legal_q;
                    state    <= RETIRE;
                end
                RETIRE: begin
                    if (legal_q && cmp_q) begin
                        flag_z <= result_q[0];
                    end else if (legal_q) begin
                        flag_z <= (result_q == '0);
                        flag_n <= result_q[WORD_SIZE-1];
                    end
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The writeback is the later assignment, so it wins an address clash.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                rf[wr_addr] <= wr_data;
            end
            if (wb_en) begin
                rf[rx_q] <= result_q;
            end
        end
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue-side controller for the `alu` block in the OrgaSmall datapath. It accepts one instruction at a time through a valid/ready handshake and holds an 8×WORD_SIZE register file. For each instruction it decodes the opcode, drives the ALU's operand and operation inputs from registered values, captures the ALU result, and writes it back to the register file. It also updates the zero and negative flags.

## Interface

- `WORD_SIZE`, default 16: datapath width. It must equal the `WORD_SIZE` of the attached `alu`.

Ports:

- `clk` in 1: single clock; every register updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: an instruction is presented.
- `instr_ready` out 1: the sequencer can accept an instruction.
- `instr` in 16: instruction word.
  - [15:11] opcode
  - [10:8] Rx, the destination and A source
  - [7:5] Ry, the B source
  - [4:0] ignored
- `alu_a` out WORD_SIZE: operand A to the ALU (registered).
- `alu_b` out WORD_SIZE: operand B to the ALU (registered).
- `alu_op` out 4: ALU operation code (registered). Encoding: ADD=0, SUB=1, LEFT_SHIFT=2, RIGHT_SHIFT_ARITHMETIC=3, RIGHT_SHIFT_LOGIC=4, AND=5, OR=6, XOR=7, EQUAL=8.
- `alu_out` in WORD_SIZE: combinational ALU result.
- `wr_en` in 1: external register-file write enable.
- `wr_addr` in 3: external write address.
- `wr_data` in WORD_SIZE: external write data.
- `rd_addr` in 3: debug read address.
- `rd_data` out WORD_SIZE: combinational read of the register at `rd_addr`.
- `flag_z` out 1: zero flag.
- `flag_n` out 1: negative flag, equal to the result MSB.
- `done` out 1: one-cycle pulse when an instruction retires.
- `illegal` out 1: one-cycle pulse when an instruction retires with an undefined opcode.

## Operation

**Opcode decode** (`instr[15:11]` → `alu_op`):

- 0x01 ADD → 0
- 0x02 SUB → 1
- 0x03 AND → 5
- 0x04 OR → 6
- 0x05 XOR → 7
- 0x06 SHL → 2
- 0x07 SHRA → 3
- 0x08 SHRL → 4
- 0x09 CMP → 8
- Any other value is illegal.

**State machine:** IDLE → ISSUE → CAPTURE → RETIRE → IDLE.

- **IDLE**
  - `instr_ready` = 1.
  - On `instr_valid` && `instr_ready`, latch the following, then go to ISSUE:
    - the decoded `alu_op`;
    - `alu_a` ← reg[Rx] and `alu_b` ← reg[Ry], using pre-edge register-file values;
    - Rx and a legal/illegal bit.
- **ISSUE**
  - `alu_a`, `alu_b` and `alu_op` are stable.
  - The ALU settles.
  - Go to CAPTURE.
- **CAPTURE**
  - Latch `alu_out` into the result register.
  - Go to RETIRE.
- **RETIRE**
  - `done` = 1 for this cycle.
  - Legal non-CMP opcode: write the result to reg[Rx]. Set `flag_z` = (result == 0) and `flag_n` = result[WORD_SIZE-1].
  - CMP: no register write. Set `flag_z` = result[0], meaning the operands were equal. `flag_n` is unchanged.
  - Illegal opcode: `illegal` = 1, no register write, flags unchanged.
  - Go to IDLE.
- When illegal, `alu_op` is driven to 0 (ADD) and its result is discarded.

**Register file:**

- 8 entries, reset to 0.
- An external write (`wr_en`) is honoured in every state.
- If the external write and a RETIRE writeback target the same address in the same cycle, the internal writeback wins.
- Different addresses in the same cycle: both writes occur.

**Other rules:**

- The same register may be used for both sources, for the destination and a source, or for all three.
- Operands are sampled only at acceptance. External writes made after acceptance do not affect the instruction in flight.
- All arithmetic is modulo 2^WORD_SIZE. The sequencer does not modify or extend the ALU result.

## Timing

- **Reset values:**
  - `instr_ready`, `alu_a`, `alu_b`, `alu_op`, `flag_z`, `flag_n`, `done`, `illegal`: `instr_ready` = 1; all the others 0.
  - All registers are 0, so `rd_data` = 0.
  - Reset asserted mid-instruction aborts it: no writeback, no `done`, state IDLE.
- **Latency:** handshake accepted at edge N → `done` high during the cycle after edge N+2. The register file and flags are updated at edge N+3.
- **Throughput:** one instruction per 4 cycles.
  - `instr_ready` drops the cycle after acceptance and rises again in the cycle after the RETIRE cycle.
  - Back-to-back instructions see the previous writeback.
- **Handshake:** `instr_valid` may be held high indefinitely. Only one instruction is accepted per IDLE visit. `instr` is ignored when `instr_valid` is low.
- **Output registration:** `alu_a`, `alu_b` and `alu_op` are registered and hold their value until the next acceptance.
- **Pulse width:** `done` and `illegal` are registered single-cycle pulses.

## Test plan

1. **ADD:** preload R1=0x0003, R2=0x0005; issue ADD R1,R2 → after 3 edges R1=0x0008, `done`=1, `flag_z`=0, `flag_n`=0.
2. **SUB to zero, then wrap:** R3=R4=0x1234; SUB R3,R4 → R3=0, `flag_z`=1. Then SUB R3,R4 → R3=0xEDCC, `flag_n`=1.
3. **CMP:** R5=0x00FF, R6=0x00FF; CMP R5,R6 → `flag_z`=1, R5 unchanged, `flag_n` unchanged. With R6=0x00FE → `flag_z`=0.
4. **Illegal opcode:** issue opcode 0x1F → `illegal` and `done` pulse together, no register changes, flags unchanged. Hold `instr_valid` high with ADD behind it → it is accepted exactly once, 4 cycles after the first acceptance.
5. **Write collision:** during RETIRE of ADD R1,R2 (result 0x0008), external `wr_en` to R1 with 0xAAAA → R1=0x0008. In the same scenario, an external write to R7 → R7=0xAAAA.
6. **Reset mid-op:** pull `rst_n` low during CAPTURE → all outputs at reset values, all registers 0, no `done`. After release, a new ADD completes normally.
